sram_port_arbiter: RTL and testbench

Shares the single external SRAM port between the instruction-fetch stage and the memory stage of the pipelined ARM core. It grants one fixed-length SRAM access at a time and holds the SRAM bus stable for the full access. It returns read data and a one-cycle ready pulse to the granted requester. It also produces the stall signal that freezes the pipeline while a data access is outstanding.

---
 rtl/sram_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_sram_port_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one external SRAM port between the instruction
// fetch stage and the memory stage. One fixed-length access is granted at a
// time. The SRAM bus is registered and held stable for the whole access. The
// granted requester gets read data and a one-cycle ready pulse.
// mem_stall freezes the pipeline while a data access is outstanding.
//
// Optional feature: define ARB_ROUND_ROBIN_EN to replace fixed MEM-over-IF
// priority with alternating priority when both requesters are pending.
module sram_port_arbiter #(
    parameter int WAIT_CYCLES = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_rd_en,
    input  logic              mem_wr_en,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              mem_stall,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              sram_ce,
    output logic              sram_we,
    input  logic [DATA_W-1:0] sram_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic [1:0] {KIND_IF, KIND_RD, KIND_WR} kind_t;

    state_t            state;
    kind_t             kind;
    logic [3:0]        count;
    logic              flushed;
    logic              if_ready_q;
    logic              mem_ready_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] if_rdata_prev;
    logic [DATA_W-1:0] mem_rdata_q;
    logic              mem_pend;
    logic              grant_mem;

    assign mem_pend = mem_rd_en | mem_wr_en;

`ifdef ARB_ROUND_ROBIN_EN
    // Set when the most recent grant went to MEM. Reset value 0 means MEM
    // wins the first contested arbitration.
    logic last_mem;

    assign grant_mem = mem_pend & (~if_req | ~last_mem);

    // Remember which requester was served so a contested grant alternates.
    always_ff @(posedge clk) begin
        if (rst)
            last_mem <= 1'b0;
        else if (state == IDLE && (mem_pend || if_req))
            last_mem <= grant_mem;
    end
`else
    // MEM always wins. A MEM stall freezes IF, so serving IF first could deadlock.
    assign grant_mem = mem_pend;
`endif

    // Access sequencer: grant in IDLE, hold the bus for WAIT_CYCLES, then
    // pulse the requester's ready for one cycle.
    // NOTE: every register here uses non-blocking assignment. All of them then
    // sample pre-edge values, which keeps this block order independent.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            kind          <= KIND_IF;
            count         <= '0;
            flushed       <= 1'b0;
            sram_ce       <= 1'b0;
            sram_we       <= 1'b0;
            sram_addr     <= '0;
            sram_wdata    <= '0;
            if_ready_q    <= 1'b0;
            mem_ready_q   <= 1'b0;
            if_rdata_q    <= '0;
            if_rdata_prev <= '0;
            mem_rdata_q   <= '0;
        end else begin
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_pend || if_req) begin
                        state   <= ACCESS;
                        count   <= 4'(WAIT_CYCLES - 1);
                        flushed <= 1'b0;
                        sram_ce <= 1'b1;
                        if (grant_mem) begin
                            // A simultaneous read+write request is served as a write.
                            kind       <= mem_wr_en ? KIND_WR : KIND_RD;
                            sram_we    <= mem_wr_en;
                            sram_addr  <= mem_addr;
                            sram_wdata <= mem_wdata;
                        end else begin
                            kind       <= KIND_IF;
                            sram_we    <= 1'b0;
                            sram_addr  <= if_addr;
                            sram_wdata <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (count == 4'd0) begin
                        state   <= RESP;
                        sram_ce <= 1'b0;
                        sram_we <= 1'b0;
                        case (kind)
                            KIND_RD: begin
                                mem_rdata_q <= sram_rdata;
                                mem_ready_q <= 1'b1;
                            end
                            KIND_WR: mem_ready_q <= 1'b1;
                            default: begin
                                // A flushed fetch finishes on the bus but is never delivered.
                                if (!(flushed || if_flush)) begin
                                    if_rdata_prev <= if_rdata_q;
                                    if_rdata_q    <= sram_rdata;
                                    if_ready_q    <= 1'b1;
                                end
                            end
                        endcase
                    end else begin
                        count <= count - 4'd1;
                        if (kind == KIND_IF && if_flush)
                            flushed <= 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    // A flush during the ready cycle discards the fetched word.
                    if (if_ready_q && if_flush)
                        if_rdata_q <= if_rdata_prev;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A flush in the ready cycle masks the pulse and shows the old instruction.
    assign if_ready  = if_ready_q & ~if_flush;
    assign if_rdata  = (if_ready_q && if_flush) ? if_rdata_prev : if_rdata_q;
    assign mem_ready = mem_ready_q;
    assign mem_rdata = mem_rdata_q;
    assign mem_stall = mem_pend & ~mem_ready_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Testbench for sram_port_arbiter. Directed scenarios are followed by
// randomized requester traffic. A transaction-level reference model tracks
// grant edges and predicts every output in every cycle.
// Honours ARB_ROUND_ROBIN_EN when it is defined.
module tb_sram_port_arbiter;

    localparam int W  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, if_flush, if_ready;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          mem_rd_en, mem_wr_en, mem_ready, mem_stall;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata, sram_rdata;
    logic          sram_ce, sram_we;

    always #5 clk = ~clk;

    sram_port_arbiter #(.WAIT_CYCLES(W), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .mem_stall(mem_stall),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_ce(sram_ce),
        .sram_we(sram_we), .sram_rdata(sram_rdata)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    typedef enum {K_IF, K_RD, K_WR} tkind_t;
    int          k = 0;          // number of rising edges so far
    bit          m_busy = 0;     // an access granted at edge m_g is in flight
    int          m_g = 0;
    tkind_t      m_kind = K_IF;
    logic [31:0] m_addr = '0, m_wdata = '0;
    bit          m_flushed = 0;
    logic [31:0] m_tent = '0;    // fetched word awaiting delivery
    logic [31:0] m_if_rdata = '0, m_mem_rdata = '0;
    bit          m_last_mem = 0;

    // Advance the model across one rising edge using the current inputs.
    task automatic model_edge();
        bit pick_mem;
        k++;
        if (rst) begin
            m_busy = 0; m_if_rdata = '0; m_mem_rdata = '0; m_last_mem = 0;
            return;
        end
        if (m_busy) begin
            if (m_kind == K_IF && if_flush && k > m_g && k <= m_g + W + 1)
                m_flushed = 1;
            if (k == m_g + W) begin
                if (m_kind == K_RD) m_mem_rdata = sram_rdata;
                if (m_kind == K_IF && !m_flushed) m_tent = sram_rdata;
            end
            if (k == m_g + W + 1) begin
                if (m_kind == K_IF && !m_flushed) m_if_rdata = m_tent;
                m_busy = 0;
            end
        end else if (mem_rd_en || mem_wr_en || if_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            pick_mem = (mem_rd_en || mem_wr_en) && (!if_req || !m_last_mem);
`else
            pick_mem = mem_rd_en || mem_wr_en;
`endif
            m_busy = 1; m_g = k; m_flushed = 0; m_last_mem = pick_mem;
            if (pick_mem) begin
                m_kind  = mem_wr_en ? K_WR : K_RD;
                m_addr  = mem_addr;
                m_wdata = mem_wdata;
            end else begin
                m_kind = K_IF;
                m_addr = if_addr;
            end
        end
    endtask

    // Compare every output against the model for the cycle after edge k.
    task automatic check_outputs();
        bit acc, resp, exp_mr, exp_ir;
        acc    = m_busy && k < m_g + W;
        resp   = m_busy && k == m_g + W;
        exp_mr = resp && m_kind != K_IF;
        exp_ir = resp && m_kind == K_IF && !m_flushed && !if_flush;
        check("sram_ce", sram_ce, acc);
        check("sram_we", sram_we, acc && m_kind == K_WR);
        if (acc) check("sram_addr", sram_addr, m_addr);
        if (acc && m_kind == K_WR) check("sram_wdata", sram_wdata, m_wdata);
        check("mem_ready", mem_ready, exp_mr);
        check("if_ready", if_ready, exp_ir);
        check("mem_rdata", mem_rdata, m_mem_rdata);
        check("if_rdata", if_rdata, exp_ir ? m_tent : m_if_rdata);
        check("mem_stall", mem_stall, (mem_rd_en || mem_wr_en) && !exp_mr);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int ce_cnt, we_cnt, rdy_cnt, rdy_at, mem_at, if_at;
        logic [31:0] prev_if;
        rst = 1; if_req = 0; if_addr = '0; if_flush = 0;
        mem_rd_en = 0; mem_wr_en = 0; mem_addr = '0; mem_wdata = '0;
        sram_rdata = '0;
        @(negedge clk);
        step(); step();
        check("reset_addr", sram_addr, 32'h0);
        check("reset_wdata", sram_wdata, 32'h0);
        check("reset_ce", sram_ce, 1'b0);
        rst = 0;
        step();

        // Fetch from 0x10 returning 0xE3A01005.
        if_req = 1; if_addr = 32'h10;
        ce_cnt = 0; rdy_cnt = 0; rdy_at = -1;
        for (int i = 0; i < W + 2; i++) begin
            step();
            if (sram_ce) ce_cnt++;
            if (if_ready) begin
                rdy_cnt++; rdy_at = i;
                check("fetch_data", if_rdata, 32'hE3A01005);
                if_req = 0;
            end
            sram_rdata = (i == W - 1) ? 32'hE3A01005 : $urandom;
        end
        check("fetch_ce_cycles", ce_cnt, W);
        check("fetch_ready_count", rdy_cnt, 1);
        check("fetch_ready_time", rdy_at, W);

        // Data write of 0xDEADBEEF to 0x400.
        mem_wr_en = 1; mem_addr = 32'h400; mem_wdata = 32'hDEADBEEF;
        we_cnt = 0; rdy_cnt = 0;
        for (int i = 0; i < W + 2; i++) begin
            step();
            if (sram_we && sram_ce) we_cnt++;
            if (mem_ready) begin rdy_cnt++; mem_wr_en = 0; end
            sram_rdata = $urandom;
        end
        check("write_we_cycles", we_cnt, W);
        check("write_ready_count", rdy_cnt, 1);
        check("write_rdata_kept", mem_rdata, 32'h0);

        // IF and MEM read request in the same cycle.
        mem_rd_en = 1; mem_addr = 32'h600; if_req = 1; if_addr = 32'h14;
        mem_at = -1; if_at = -1;
        for (int i = 0; i < 2 * (W + 2) + 2; i++) begin
            step();
            if (mem_ready) begin mem_at = i; mem_rd_en = 0; end
            if (if_ready) begin if_at = i; if_req = 0; end
            sram_rdata = $urandom;
        end
`ifdef ARB_ROUND_ROBIN_EN
        check("contend_if_first", if_at, W);
        check("contend_mem_second", mem_at, 2 * W + 2);
`else
        check("contend_mem_first", mem_at, W);
        check("contend_if_second", if_at, 2 * W + 2);
`endif

        // Flush in the second ACCESS cycle of a fetch.
        prev_if = m_if_rdata;
        if_req = 1; if_addr = 32'h20;
        ce_cnt = 0; rdy_cnt = 0;
        for (int i = 0; i < W + 2; i++) begin
            step();
            if (sram_ce) ce_cnt++;
            if (if_ready) rdy_cnt++;
            if_flush = (i == 1);
            if (i == 1) if_req = 0;
            sram_rdata = $urandom;
        end
        check("flush_ce_cycles", ce_cnt, W);
        check("flush_no_ready", rdy_cnt, 0);
        check("flush_rdata_kept", if_rdata, prev_if);

        // Reset in the third ACCESS cycle of a data read.
        mem_rd_en = 1; mem_addr = 32'h800;
        for (int i = 0; i < 3; i++) begin
            step();
            sram_rdata = $urandom;
        end
        rst = 1;
        step();
        check("abort_ce", sram_ce, 1'b0);
        check("abort_we", sram_we, 1'b0);
        check("abort_mem_ready", mem_ready, 1'b0);
        check("abort_if_ready", if_ready, 1'b0);
        check("abort_addr", sram_addr, 32'h0);
        check("abort_wdata", sram_wdata, 32'h0);
        check("abort_if_rdata", if_rdata, 32'h0);
        check("abort_mem_rdata", mem_rdata, 32'h0);
        rst = 0; mem_rd_en = 0;
        step();

        // Read and write requested together: served as a write.
        mem_rd_en = 1; mem_wr_en = 1; mem_addr = 32'h404; mem_wdata = 32'h12345678;
        we_cnt = 0; rdy_cnt = 0;
        for (int i = 0; i < W + 2; i++) begin
            step();
            if (sram_we && sram_ce) we_cnt++;
            if (mem_ready) begin rdy_cnt++; mem_rd_en = 0; mem_wr_en = 0; end
            sram_rdata = $urandom;
        end
        check("rdwr_we_cycles", we_cnt, W);
        check("rdwr_ready_count", rdy_cnt, 1);
        check("rdwr_rdata_kept", mem_rdata, 32'h0);

        // Random traffic obeying the requester handshakes.
        for (int i = 0; i < 600; i++) begin
            step();
            sram_rdata = $urandom;
            if_flush = 0;
            rst = ($urandom_range(249) == 0);
            if (mem_ready) begin
                mem_rd_en = 0; mem_wr_en = 0;
            end else if (!(mem_rd_en || mem_wr_en) && $urandom_range(3) == 0) begin
                case ($urandom_range(2))
                    0: mem_rd_en = 1;
                    1: mem_wr_en = 1;
                    default: begin mem_rd_en = 1; mem_wr_en = 1; end
                endcase
                mem_addr = $urandom & 32'hFFFF_FFFC;
                mem_wdata = $urandom;
            end
            if (if_ready) begin
                if_req = 0;
            end else if (if_req && $urandom_range(11) == 0) begin
                if_flush = 1; if_req = 0;
            end else if (!if_req && $urandom_range(2) == 0) begin
                if_req = 1;
                if_addr = $urandom & 32'hFFFF_FFFC;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
